// File: rtl/tag_compare.sv
// DRAM-cache tag comparator: classifies each accepted R-channel beat as read/write hit/miss
// and steers its data into one of four registered outputs. Optional macro: TAG_CMP_VALID_OUT_EN.
module tag_compare #(
    parameter int DATA_W  = 72,
    parameter int TAG_W   = 56,
    parameter int FIFO_W  = 81,
    parameter int TAG_LSB = 8,
    parameter int WR_BIT  = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [TAG_W-1:0]  rtag_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [FIFO_W-1:0] fifo_data_i,
    output logic [DATA_W-1:0] r_hit_data_o,
    output logic [DATA_W-1:0] r_miss_data_o,
    output logic [DATA_W-1:0] w_hit_data_o,
    output logic [DATA_W-1:0] w_miss_data_o
`ifdef TAG_CMP_VALID_OUT_EN
   ,output logic              r_hit_valid_o,
    output logic              r_miss_valid_o,
    output logic              w_hit_valid_o,
    output logic              w_miss_valid_o
`endif
);

    // Encoding is {write, miss} so the class falls straight out of the two decode bits.
    typedef enum logic [1:0] {
        RD_HIT  = 2'b00,
        RD_MISS = 2'b01,
        WR_HIT  = 2'b10,
        WR_MISS = 2'b11
    } beat_class_e;

    logic              r_rready;
    logic [DATA_W-1:0] r_rd_hit;
    logic [DATA_W-1:0] r_rd_miss;
    logic [DATA_W-1:0] r_wr_hit;
    logic [DATA_W-1:0] r_wr_miss;

    logic        w_accept;
    logic        w_hit;
    logic        w_wr;
    logic        w_unused;
    beat_class_e w_class;

    assign w_accept = rvalid_i & r_rready;
    assign w_hit    = (rtag_i == fifo_data_i[TAG_LSB +: TAG_W]);
    assign w_wr     = fifo_data_i[WR_BIT];
    assign w_class  = beat_class_e'({w_wr, ~w_hit});

    // Request ID and reserved bits ride along in the FIFO word but never steer anything.
    assign w_unused = ^{fifo_data_i[WR_BIT-1:TAG_LSB+TAG_W], fifo_data_i[TAG_LSB-1:0]};

    // NOTE: every register here is cleared by the asynchronous reset and updated with
    // non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rready  <= 1'b0;
            r_rd_hit  <= '0;
            r_rd_miss <= '0;
            r_wr_hit  <= '0;
            r_wr_miss <= '0;
        end else begin
            r_rready <= 1'b1;
            if (w_accept) begin
                unique case (w_class)
                    RD_HIT:  r_rd_hit  <= rdata_i;
                    RD_MISS: r_rd_miss <= rdata_i;
                    WR_HIT:  r_wr_hit  <= rdata_i;
                    WR_MISS: r_wr_miss <= rdata_i;
                endcase
            end
        end
    end

    assign rready_o      = r_rready;
    assign r_hit_data_o  = r_rd_hit;
    assign r_miss_data_o = r_rd_miss;
    assign w_hit_data_o  = r_wr_hit;
    assign w_miss_data_o = r_wr_miss;

`ifdef TAG_CMP_VALID_OUT_EN
    logic r_rd_hit_vld;
    logic r_rd_miss_vld;
    logic r_wr_hit_vld;
    logic r_wr_miss_vld;

    // Strobes mark which data register was written on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_hit_vld  <= 1'b0;
            r_rd_miss_vld <= 1'b0;
            r_wr_hit_vld  <= 1'b0;
            r_wr_miss_vld <= 1'b0;
        end else begin
            r_rd_hit_vld  <= w_accept && (w_class == RD_HIT);
            r_rd_miss_vld <= w_accept && (w_class == RD_MISS);
            r_wr_hit_vld  <= w_accept && (w_class == WR_HIT);
            r_wr_miss_vld <= w_accept && (w_class == WR_MISS);
        end
    end

    assign r_hit_valid_o  = r_rd_hit_vld;
    assign r_miss_valid_o = r_rd_miss_vld;
    assign w_hit_valid_o  = r_wr_hit_vld;
    assign w_miss_valid_o = r_wr_miss_vld;
`endif

endmodule

// File: tb/tb_tag_compare.sv
// Scoreboard bench for tag_compare: directed beats push hand-computed expected outputs,
// a negedge monitor pops and compares them one cycle later.
module tb_tag_compare;

    localparam int DATA_W = 72;
    localparam int TAG_W  = 56;
    localparam int FIFO_W = 81;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rdata_i;
    logic [TAG_W-1:0]  rtag_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [FIFO_W-1:0] fifo_data_i;
    logic [DATA_W-1:0] r_hit_data_o;
    logic [DATA_W-1:0] r_miss_data_o;
    logic [DATA_W-1:0] w_hit_data_o;
    logic [DATA_W-1:0] w_miss_data_o;
    logic [3:0]        stb;
`ifdef TAG_CMP_VALID_OUT_EN
    logic r_hit_valid_o, r_miss_valid_o, w_hit_valid_o, w_miss_valid_o;
    assign stb = {r_hit_valid_o, r_miss_valid_o, w_hit_valid_o, w_miss_valid_o};
`else
    assign stb = 4'b0000;
`endif

    tag_compare dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdata_i       (rdata_i),
        .rtag_i        (rtag_i),
        .rvalid_i      (rvalid_i),
        .rready_o      (rready_o),
        .fifo_data_i   (fifo_data_i),
        .r_hit_data_o  (r_hit_data_o),
        .r_miss_data_o (r_miss_data_o),
        .w_hit_data_o  (w_hit_data_o),
        .w_miss_data_o (w_miss_data_o)
`ifdef TAG_CMP_VALID_OUT_EN
       ,.r_hit_valid_o (r_hit_valid_o),
        .r_miss_valid_o(r_miss_valid_o),
        .w_hit_valid_o (w_hit_valid_o),
        .w_miss_valid_o(w_miss_valid_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              vld;
        logic              wr;
        logic [TAG_W-1:0]  ftag;
        logic [TAG_W-1:0]  rtag;
        logic [15:0]       id;
        logic [7:0]        rsv;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] e_rh, e_rm, e_wh, e_wm;
        logic [3:0]        e_stb;
    } vec_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] rh, rm, wh, wm;
        logic [3:0]        stb;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("r_hit@%0d", e.due),  r_hit_data_o,  e.rh);
            check($sformatf("r_miss@%0d", e.due), r_miss_data_o, e.rm);
            check($sformatf("w_hit@%0d", e.due),  w_hit_data_o,  e.wh);
            check($sformatf("w_miss@%0d", e.due), w_miss_data_o, e.wm);
`ifdef TAG_CMP_VALID_OUT_EN
            check($sformatf("strobes@%0d", e.due), DATA_W'(stb), DATA_W'(e.stb));
`endif
        end
    end

    task automatic add(input logic vld, input logic wr, input logic [TAG_W-1:0] ftag,
                       input logic [TAG_W-1:0] rtag, input logic [15:0] id, input logic [7:0] rsv,
                       input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] rh,
                       input logic [DATA_W-1:0] rm, input logic [DATA_W-1:0] wh,
                       input logic [DATA_W-1:0] wm, input logic [3:0] s);
        vec_t v;
        v.vld = vld; v.wr = wr; v.ftag = ftag; v.rtag = rtag; v.id = id; v.rsv = rsv;
        v.data = data; v.e_rh = rh; v.e_rm = rm; v.e_wh = wh; v.e_wm = wm; v.e_stb = s;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rvalid_i    = v.vld;
        rdata_i     = v.data;
        rtag_i      = v.rtag;
        fifo_data_i = {v.wr, v.id, v.ftag, v.rsv};
        e.due = cyc + 1;
        e.rh = v.e_rh; e.rm = v.e_rm; e.wh = v.e_wh; e.wm = v.e_wm; e.stb = v.e_stb;
        sb.push_back(e);
    endtask

    localparam logic [TAG_W-1:0]  ONES_T = {TAG_W{1'b1}};
    localparam logic [DATA_W-1:0] ONES_D = {DATA_W{1'b1}};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rtag_i = '0; fifo_data_i = '0;

        // Hold reset across one edge, check cleared state, release between edges.
        @(posedge clk); #2;
        check("rst_r_hit", r_hit_data_o, '0);
        check("rst_r_miss", r_miss_data_o, '0);
        check("rst_w_hit", w_hit_data_o, '0);
        check("rst_w_miss", w_miss_data_o, '0);
        check("rst_rready", DATA_W'(rready_o), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rready_after_release", DATA_W'(rready_o), 72'd1);

        //  vld wr ftag  rtag  id        rsv    data     rh   rm   wh      wm   strobes
        add(1, 0, 56'd10, 56'd10, 16'hABCD, 8'h5A, 72'd100, 100, 0,   0,      0,   4'b1000);
        add(1, 0, 56'd10, 56'd20, 16'h0000, 8'h00, 72'd200, 100, 200, 0,      0,   4'b0100);
        add(1, 1, 56'd10, 56'd10, 16'h1234, 8'hFF, 72'd300, 100, 200, 300,    0,   4'b0010);
        add(1, 1, 56'd10, 56'd20, 16'hFFFF, 8'h01, 72'd400, 100, 200, 300,    400, 4'b0001);
        add(0, 1, 56'd10, 56'd10, 16'h5555, 8'h00, 72'd555, 100, 200, 300,    400, 4'b0000);
        add(0, 0, 56'd10, 56'd10, 16'hAAAA, 8'h00, 72'd666, 100, 200, 300,    400, 4'b0000);
        add(1, 0, 56'd0,  56'd0,  16'hFFFF, 8'hFF, 72'd7,   7,   200, 300,    400, 4'b1000);
        add(1, 0, 56'd0,  56'd0,  16'hFFFF, 8'hFF, 72'd7,   7,   200, 300,    400, 4'b1000);
        add(1, 1, ONES_T, 56'h7F_FFFF_FFFF_FFFF, 16'h0F0F, 8'h3C, 72'd9,
            7, 200, 300, 9, 4'b0001);
        add(1, 1, ONES_T, ONES_T, 16'hF0F0, 8'hC3, ONES_D, 7, 200, ONES_D, 9, 4'b0010);
        add(1, 0, 56'h12_3456_789A_BCDE, 56'h12_3456_789A_BCDF, 16'h0001, 8'h80, 72'd11,
            7, 11, ONES_D, 9, 4'b0100);
        add(1, 0, 56'd5, 56'd5, 16'hBEEF, 8'h7E, 72'd12, 12, 11, ONES_D, 9, 4'b1000);
        add(0, 0, 56'd5, 56'd5, 16'h0000, 8'h00, 72'd13, 12, 11, ONES_D, 9, 4'b0000);

        foreach (vecs[i]) drive(vecs[i]);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", DATA_W'(sb.size()), '0);

        // Mid-cycle reset with a beat in flight: outputs clear at once and the beat is lost.
        @(posedge clk); #1;
        rvalid_i = 1'b1; rdata_i = 72'd77; rtag_i = 56'd3; fifo_data_i = {1'b0, 16'd0, 56'd3, 8'd0};
        #2 rst_n = 1'b0;
        #1;
        check("async_r_hit", r_hit_data_o, '0);
        check("async_r_miss", r_miss_data_o, '0);
        check("async_w_hit", w_hit_data_o, '0);
        check("async_w_miss", w_miss_data_o, '0);
        check("async_rready", DATA_W'(rready_o), '0);
        @(posedge clk); #1;
        check("inflight_dropped", r_hit_data_o, '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rvalid_i = 1'b0;
        check("rready_relaunch", DATA_W'(rready_o), 72'd1);
        check("no_accept_while_not_ready", r_hit_data_o, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tag_compare.md
Name: tag_compare

Overview:
- DRAM-cache tag comparator sitting between the AXI R channel (tag+data read back from the DRAM cache) and the reordering buffer.
- Compares the returned tag against the expected tag of the oldest pending request (supplied by the request FIFO).
- Steers the returned data beat to one of four registered outputs: read-hit, read-miss, write-hit or write-miss.

Parameters:
- DATA_W, 72, width of the R-channel data beat and of each steered output.
- TAG_W, 56, width of the stored and returned tag.
- FIFO_W, 81, width of the FIFO request word.
- TAG_LSB, 8, LSB position of the expected tag in the FIFO word; the tag occupies [TAG_LSB+TAG_W-1 : TAG_LSB] = [63:8].
- WR_BIT, 80, FIFO word bit carrying the request type: 1 = write, 0 = read.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rdata_i  input  DATA_W  R-channel data beat.
- rtag_i  input  TAG_W  tag returned with the beat.
- rvalid_i  input  1  R-channel valid.
- rready_o  output  1  R-channel ready.
- fifo_data_i  input  FIFO_W  head-of-FIFO request word: [80] type, [79:64] request ID (carried, unused here), [63:8] expected tag, [7:0] reserved.
- r_hit_data_o  output  DATA_W  data of the last read hit.
- r_miss_data_o  output  DATA_W  data of the last read miss.
- w_hit_data_o  output  DATA_W  data of the last write hit.
- w_miss_data_o  output  DATA_W  data of the last write miss.

Behaviour:
- Clocking and reset: single clock domain (clk). rst_n asserted (low) asynchronously clears all four data outputs to 0 and drives rready_o to 0.
- rready_o: registered. Goes to 1 on the first rising edge after rst_n deasserts and stays 1 (no backpressure). Forced to 0 again immediately on any reset assertion.
- Accept condition: accept = rvalid_i & rready_o, sampled at the rising edge.
- hit = (rtag_i == fifo_data_i[63:8]), full 56-bit equality, purely combinational.
- Classification on accept:
  - wr = fifo_data_i[WR_BIT].
  - wr=0, hit=1: r_hit_data_o <= rdata_i.
  - wr=0, hit=0: r_miss_data_o <= rdata_i.
  - wr=1, hit=1: w_hit_data_o <= rdata_i.
  - wr=1, hit=0: w_miss_data_o <= rdata_i.
- Exactly one output register updates per accepted beat; the other three hold their previous values.
- Latency: one cycle. The output is valid after the rising edge that samples the accept.
- No accept (rvalid_i=0 or rready_o=0): all outputs hold.
- Inputs held steady across several cycles with rvalid_i=1: the same output is rewritten each cycle with the same value. The block is stateless apart from the output registers.
- Tag value 0 is compared like any other value: 0 vs 0 is a hit.
- Reset asserted mid-operation: all outputs clear immediately; any in-flight beat is dropped.
- No X propagation from fifo_data_i[79:64] or [7:0]; these bits do not affect any output.

Optional Feature:
- Macro TAG_CMP_VALID_OUT_EN.
- When defined: adds four outputs r_hit_valid_o, r_miss_valid_o, w_hit_valid_o, w_miss_valid_o, each 1 bit and registered.
  - The strobe matching the updated data register is 1 for exactly the cycle after an accept; all others are 0.
  - All strobes reset to 0.
- When undefined: these ports and their logic do not exist. Data behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for one cycle -> all four data outputs = 0, rready_o = 0. First edge after release -> rready_o = 1.
- Read hit: rvalid_i=1, fifo[80]=0, fifo[63:8]=10, rtag_i=10, rdata_i=100 -> after one edge r_hit_data_o=100; other outputs unchanged (0).
- Read miss: fifo[80]=0, fifo tag=10, rtag_i=20, rdata_i=200 -> r_miss_data_o=200; r_hit_data_o still 100.
- Write hit: fifo[80]=1, fifo tag=10, rtag_i=10, rdata_i=300 -> w_hit_data_o=300.
- Write miss: fifo[80]=1, fifo tag=10, rtag_i=20, rdata_i=400 -> w_miss_data_o=400. Final state: 100/200/300/400 across r_hit/r_miss/w_hit/w_miss.
- Hold and reset: rvalid_i=0 with changing rdata_i -> all outputs hold. Then assert rst_n=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
